ram8_16: RTL

- 8-word × 16-bit clocked register file: the storage/write side that pairs with the existing 8-way 16-bit read mux.
- The write path demultiplexes one input word to one of 8 registers by a 3-bit address. The read path selects one register by the same address.
- An internal sequencer performs a multi-cycle "clear all" operation with a busy indication.
- This is the first sequential block in the gate library and is the building block for the RAM64/RAM512 hierarchy.

---
 rtl/ram8_16.sv | 103 ++++++++++
 1 files changed

// File: rtl/ram8_16.sv
// ram8_16 -- 8-word x WIDTH-bit clocked register file with a sequenced
// "clear all" operation. It is the storage/write side that pairs with the
// existing 8-way read mux and is the building block for larger RAMs.
//
// All data and address vectors are MSB-first (bit 0 is the MSB), so they
// are declared [0:N-1]. The numeric value of in_addr is the word index.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   in_d     in   write data
//   in_we    in   write enable (sampled on clk)
//   in_addr  in   word select, read and write
//   in_clr   in   clear-all request (sampled on clk)
//   out_q    out  word[in_addr], combinational
//   out_busy out  high while the clear sequence runs
module ram8_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] in_d,
    input  logic             in_we,
    input  logic [0:2]       in_addr,
    input  logic             in_clr,
    output logic [0:WIDTH-1] out_q,
    output logic             out_busy
);

    localparam int          NUM_WORDS = 8;
    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  CLEAR     = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [0:WIDTH-1] mem_q [NUM_WORDS];

    logic [NUM_WORDS-1:0] wr_sel;
    logic [NUM_WORDS-1:0] clr_sel;

    // Per-word strobes. A clear request on an IDLE edge wins over a write
    // on the same edge, so the write strobe is masked by in_clr.
    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_sel
        assign wr_sel[w]  = (state_q == IDLE) && in_we && !in_clr &&
                            (in_addr == 3'(w));
        assign clr_sel[w] = (state_q == CLEAR) && (cnt_q == 3'(w));
    end

    // Sequencer: the request edge loads the counter, then eight CLEAR edges
    // zero words 0..7. The counter wraps 7 -> 0 naturally on the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_clr) begin
                    state_d = CLEAR;
                    cnt_d   = 3'd0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (wr_sel[w]) begin
                    mem_q[w] <= in_d;
                end else if (clr_sel[w]) begin
                    mem_q[w] <= '0;
                end
            end
        end
    end

    assign out_q    = mem_q[in_addr];
    assign out_busy = (state_q == CLEAR);

endmodule
